// File: rtl/srt4_digit_select_if.sv
// ----------------------------------------------------------------------------
// srt4_digit_select_if
// Bundles the request, digit-stream and result handshakes of the radix-4 SRT
// iteration engine.
//   slave  : the engine (srt4_digit_select)
//   master : whoever issues divisions and consumes digits/results
// Signals:
//   input_valid / input_ready        request handshake
//   input_dividend / input_divisor   operands x (x < d) and normalized d
//   digit_valid                      one quotient digit this cycle
//   digit_selectedQuotientOH         one-hot digit {-2,-1,0,+1,+2} = bits 0..4
//   digit_first                      marks the digit of iteration 0
//   output_valid / output_ready      result handshake
//   output_remainder                 corrected, non-negative final residual
//   output_remNegative               raw residual was negative (take Q-1)
// ----------------------------------------------------------------------------
interface srt4_digit_select_if #(
    parameter int WIDTH = 32
);
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] input_dividend;
    logic [WIDTH-1:0] input_divisor;
    logic             digit_valid;
    logic [4:0]       digit_selectedQuotientOH;
    logic             digit_first;
    logic             output_valid;
    logic             output_ready;
    logic [WIDTH:0]   output_remainder;
    logic             output_remNegative;

    modport slave (
        input  input_valid,
        output input_ready,
        input  input_dividend,
        input  input_divisor,
        output digit_valid,
        output digit_selectedQuotientOH,
        output digit_first,
        output output_valid,
        input  output_ready,
        output output_remainder,
        output output_remNegative
    );

    modport master (
        output input_valid,
        input  input_ready,
        output input_dividend,
        output input_divisor,
        input  digit_valid,
        input  digit_selectedQuotientOH,
        input  digit_first,
        input  output_valid,
        output output_ready,
        input  output_remainder,
        input  output_remNegative
    );
endinterface

// File: rtl/srt4_digit_select.sv
// ----------------------------------------------------------------------------
// srt4_digit_select
// Sequential radix-4 SRT iteration engine. After a request is accepted it
// emits one one-hot quotient digit per cycle for ITER cycles, then returns
// the corrected final remainder plus a flag telling the quotient converter
// whether to pick Q or Q-1.
// Ports:
//   clock  : single clock
//   reset  : asynchronous assert, active-low
//   bus    : srt4_digit_select_if.slave (request, digit stream, result)
// ----------------------------------------------------------------------------
module srt4_digit_select #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic                clock,
    input  logic                reset,
    srt4_digit_select_if.slave  bus
);
    // Residual register holds R = 4*w: two fractional bits, so the initial
    // residual x/4 is exact and R itself equals y = 4w as an integer.
    localparam int RW = WIDTH + 4;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 w_inputReady;
    logic                 w_accept;
    logic                 w_lastIter;

    logic [WIDTH-1:0]     r_divisor;
    logic signed [RW-1:0] r_residual;
    logic [CW-1:0]        r_count;
    logic                 r_digitValid;
    logic [4:0]           r_digitOH;
    logic                 r_digitFirst;
    logic                 r_outValid;
    logic [WIDTH:0]       r_outRem;
    logic                 r_outNeg;

    // Comparison operands are in half-units (one guard bit) so 3d/2 and d/2
    // are exact integers.
    logic signed [RW:0]   w_twiceY;
    logic signed [RW:0]   w_halfD;
    logic signed [RW:0]   w_threeHalfD;
    logic signed [RW-1:0] w_dExt;
    logic signed [RW-1:0] w_diff;
    logic signed [RW-1:0] w_residualNext;
    logic [4:0]           w_digitOH;
    logic [WIDTH:0]       w_finalW;
    logic [WIDTH:0]       w_fixRem;

    assign w_accept   = (r_state == S_IDLE) && bus.input_valid;
    assign w_lastIter = (r_count == CW'(ITER - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; input_ready is only asserted while idle, so requests
    // arriving during a division are simply ignored.
    always_comb begin
        w_stateNext  = r_state;
        w_inputReady = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_inputReady = 1'b1;
                if (bus.input_valid) begin
                    w_stateNext = S_ITER;
                end
            end
            S_ITER: begin
                if (w_lastIter) begin
                    w_stateNext = S_FIX;
                end
            end
            S_FIX: begin
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                if (bus.output_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Digit selection with exact comparisons of 2y against 3d and d, then
    // w_next = y - q*d, stored back as 4*w_next.
    always_comb begin
        w_twiceY     = {r_residual, 1'b0};
        w_halfD      = {{(RW + 1 - WIDTH){1'b0}}, r_divisor};
        w_threeHalfD = {{(RW - WIDTH){1'b0}}, r_divisor, 1'b0} + w_halfD;
        w_dExt       = {{(RW - WIDTH){1'b0}}, r_divisor};
        w_digitOH    = 5'b00100;
        w_diff       = r_residual;
        if (w_twiceY >= w_threeHalfD) begin
            w_digitOH = 5'b10000;
            w_diff    = r_residual - (w_dExt <<< 1);
        end else if (w_twiceY >= w_halfD) begin
            w_digitOH = 5'b01000;
            w_diff    = r_residual - w_dExt;
        end else if (w_twiceY >= -w_halfD) begin
            w_digitOH = 5'b00100;
            w_diff    = r_residual;
        end else if (w_twiceY >= -w_threeHalfD) begin
            w_digitOH = 5'b00010;
            w_diff    = r_residual + w_dExt;
        end else begin
            w_digitOH = 5'b00001;
            w_diff    = r_residual + (w_dExt <<< 1);
        end
        w_residualNext = w_diff <<< 2;
    end

    // Final residual w = R/4; adding d to a negative w lands in [0, d).
    assign w_finalW = r_residual[WIDTH+2:2];
    assign w_fixRem = w_finalW + {1'b0, r_divisor};

    // Datapath: operand capture, one iteration per cycle, correction, and
    // result hold. Digit outputs fall back to the "0" digit when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_divisor    <= '0;
            r_residual   <= '0;
            r_count      <= '0;
            r_digitValid <= 1'b0;
            r_digitOH    <= 5'b00100;
            r_digitFirst <= 1'b0;
            r_outValid   <= 1'b0;
            r_outRem     <= '0;
            r_outNeg     <= 1'b0;
        end else begin
            r_digitValid <= 1'b0;
            r_digitOH    <= 5'b00100;
            r_digitFirst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_divisor  <= bus.input_divisor;
                        r_residual <= {{(RW - WIDTH){1'b0}}, bus.input_dividend};
                        r_count    <= '0;
                    end
                end
                S_ITER: begin
                    r_residual   <= w_residualNext;
                    r_digitValid <= 1'b1;
                    r_digitOH    <= w_digitOH;
                    r_digitFirst <= (r_count == '0);
                    r_count      <= r_count + CW'(1);
                end
                S_FIX: begin
                    r_outValid <= 1'b1;
                    if (r_residual[RW-1]) begin
                        r_outRem <= w_fixRem;
                        r_outNeg <= 1'b1;
                    end else begin
                        r_outRem <= w_finalW;
                        r_outNeg <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.output_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.input_ready              = w_inputReady;
    assign bus.digit_valid              = r_digitValid;
    assign bus.digit_selectedQuotientOH = r_digitOH;
    assign bus.digit_first              = r_digitFirst;
    assign bus.output_valid             = r_outValid;
    assign bus.output_remainder         = r_outRem;
    assign bus.output_remNegative       = r_outNeg;
endmodule

// File: tb/tb_srt4_digit_select.sv
// ----------------------------------------------------------------------------
// tb_srt4_digit_select
// Scoreboard bench for srt4_digit_select: the driver pushes the reference
// model's expected digits/remainder per accepted request, and a monitor
// process collects the digit stream and compares it when a result appears.
// ----------------------------------------------------------------------------
module tb_srt4_digit_select;
    localparam int WIDTH = 32;
    localparam int ITER  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    srt4_digit_select_if #(.WIDTH(WIDTH)) bus ();

    srt4_digit_select #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [WIDTH-1:0]      x;
        logic [WIDTH-1:0]      d;
        logic [ITER-1:0][4:0]  oh;
        longint                rem;
        bit                    remNeg;
        longint                qFloor;
        longint                remGold;
    } exp_t;

    exp_t expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    logic [ITER-1:0][4:0] dutOH;
    logic [ITER-1:0][4:0] lastOH;
    logic [WIDTH:0]       lastRem;
    int                   digCnt = 0;
    bit                   gapSeen = 0;
    bit                   resultSeen = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain integer SRT recurrence on y = 4w (w0 = x/4),
    // selecting digits straight from the threshold rules.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d);
        exp_t   e;
        longint y;
        longint w;
        longint dl;
        int     q;
        dl = longint'(d);
        y  = longint'(x);
        w  = 0;
        e.x = x;
        e.d = d;
        for (int i = 0; i < ITER; i++) begin
            if (2 * y >= 3 * dl)       q = 2;
            else if (2 * y >= dl)      q = 1;
            else if (2 * y >= -dl)     q = 0;
            else if (2 * y >= -3 * dl) q = -1;
            else                       q = -2;
            e.oh[i] = 5'(1) << (q + 2);
            w = y - q * dl;
            y = 4 * w;
        end
        e.remNeg  = (w < 0);
        e.rem     = (w < 0) ? w + dl : w;
        e.qFloor  = (longint'(x) << (2 * (ITER - 1))) / dl;
        e.remGold = (longint'(x) << (2 * (ITER - 1))) % dl;
        return e;
    endfunction

    function automatic int ohToDigit(input logic [4:0] oh);
        case (oh)
            5'b00001: return -2;
            5'b00010: return -1;
            5'b00100: return 0;
            5'b01000: return 1;
            5'b10000: return 2;
            default:  return 0;
        endcase
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "InputReady"}, bus.input_ready, 1);
        checkOutput({tag, "DigitValid"}, bus.digit_valid, 0);
        checkOutput({tag, "DigitOH"}, bus.digit_selectedQuotientOH, 5'b00100);
        checkOutput({tag, "DigitFirst"}, bus.digit_first, 0);
        checkOutput({tag, "OutputValid"}, bus.output_valid, 0);
        checkOutput({tag, "Remainder"}, bus.output_remainder, 0);
        checkOutput({tag, "RemNegative"}, bus.output_remNegative, 0);
    endtask

    // Issue one division (called at a negedge), check latency, optionally
    // poke input_valid while busy and stall output_ready, then retire it.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d,
                                 input int stall, input bit poke);
        exp_t e;
        int   waitCnt;
        int   n;
        e = model(x, d);
        waitCnt = 0;
        while (!bus.input_ready && waitCnt < 200) begin
            @(negedge clock);
            waitCnt++;
        end
        if (!bus.input_ready) begin
            checkOutput("readyTimeout", bus.input_ready, 1);
            return;
        end
        bus.input_valid    = 1'b1;
        bus.input_dividend = x;
        bus.input_divisor  = d;
        @(posedge clock);
        expQ.push_back(e);
        @(negedge clock);
        n = 0;
        bus.input_dividend = $urandom;
        bus.input_divisor  = $urandom;
        if (poke) begin
            for (int k = 0; k < 5; k++) begin
                checkOutput("busyInputReady", bus.input_ready, 0);
                @(negedge clock);
                n++;
            end
        end
        bus.input_valid = 1'b0;
        while (!bus.output_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        // Accept cycle is cycle 0; this negedge lies in cycle n+1, so a
        // result first valid in cycle ITER+2 is seen at n = ITER+1.
        checkOutput("latency", n, ITER + 1);
        for (int k = 0; k < stall; k++) begin
            @(negedge clock);
            checkOutput("stallValid", bus.output_valid, 1);
            checkOutput("stallRemainder", bus.output_remainder, e.rem);
            checkOutput("stallInputReady", bus.input_ready, 0);
            checkOutput("stallDigitValid", bus.digit_valid, 0);
        end
        bus.output_ready = 1'b1;
        @(negedge clock);
        bus.output_ready = 1'b0;
        checkOutput("retireValid", bus.output_valid, 0);
        checkOutput("retireInputReady", bus.input_ready, 1);
    endtask

    // Start a division and assert reset partway through the digit stream.
    task automatic resetMidOperation(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d);
        bus.input_valid    = 1'b1;
        bus.input_dividend = x;
        bus.input_divisor  = d;
        @(posedge clock);
        expQ.push_back(model(x, d));
        @(negedge clock);
        bus.input_valid = 1'b0;
        repeat (7) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkResetValues("midReset");
        expQ.delete();
        @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
    endtask

    // Monitor: gathers digits and scores each result against the queue head.
    initial begin
        exp_t   e;
        longint qd;
        forever begin
            @(negedge clock);
            if (!reset) begin
                digCnt     = 0;
                gapSeen    = 0;
                resultSeen = 0;
            end else begin
                if (bus.digit_valid) begin
                    if (digCnt < ITER) begin
                        dutOH[digCnt] = bus.digit_selectedQuotientOH;
                        checkOutput("digitFirst", bus.digit_first, (digCnt == 0));
                    end
                    digCnt++;
                end else if (digCnt > 0 && digCnt < ITER) begin
                    gapSeen = 1;
                end
                if (bus.output_valid && !resultSeen) begin
                    resultSeen = 1;
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpectedResult: got remainder 0x%0h, expected no result", bus.output_remainder);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("digitCount", digCnt, ITER);
                        checkOutput("digitGap", gapSeen, 0);
                        qd = 0;
                        for (int i = 0; i < ITER; i++) begin
                            checkOutput($sformatf("digit%0d", i), dutOH[i], e.oh[i]);
                            qd = qd * 4 + longint'(ohToDigit(dutOH[i]));
                        end
                        checkOutput("remainder", bus.output_remainder, e.rem);
                        checkOutput("remNegative", bus.output_remNegative, e.remNeg);
                        checkOutput("remainderGolden", bus.output_remainder, e.remGold);
                        checkOutput("quotient", qd - longint'(bus.output_remNegative), e.qFloor);
                        lastOH  = dutOH;
                        lastRem = bus.output_remainder;
                    end
                    digCnt  = 0;
                    gapSeen = 0;
                end
                if (!bus.output_valid) begin
                    resultSeen = 0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases, reset abandonment, then randomized normalized divisions.
    initial begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] d;
        int               sel;
        int               stall;
        bit               poke;
        bus.input_valid    = 1'b0;
        bus.input_dividend = '0;
        bus.input_divisor  = '0;
        bus.output_ready   = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues("reset");
        @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);

        applyStimulus(32'h4000_0000, 32'h8000_0000, 0, 0);
        checkOutput("t1Digit0", lastOH[0], 5'b01000);
        checkOutput("t1Digit1", lastOH[1], 5'b00001);
        for (int i = 2; i < ITER; i++) begin
            checkOutput($sformatf("t1Digit%0d", i), lastOH[i], 5'b00100);
        end
        checkOutput("t1Remainder", lastRem, 0);

        applyStimulus(32'h0000_0000, 32'h8000_0000, 0, 0);
        for (int i = 0; i < ITER; i++) begin
            checkOutput($sformatf("t2Digit%0d", i), lastOH[i], 5'b00100);
        end

        applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);

        applyStimulus(32'h1234_5678, 32'h9ABC_DEF1, 10, 1);
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0001, 0, 0);

        resetMidOperation(32'h5A5A_5A5A, 32'hC3C3_C3C3);
        applyStimulus(32'h5A5A_5A5A, 32'hC3C3_C3C3, 0, 0);

        for (int t = 0; t < 1500; t++) begin
            d   = $urandom | 32'h8000_0000;
            sel = $urandom_range(0, 9);
            if (sel == 0)      x = '0;
            else if (sel == 1) x = d - 1;
            else               x = $urandom % d;
            stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            poke  = ($urandom_range(0, 15) == 0);
            applyStimulus(x, d, stall, poke);
        end

        checkOutput("queueDrained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
